// File: rtl/event_sequence_ctrl.sv
// Armed event sequencer: counts trig pulses after ev1, waits delay_cyc cycles, then copies breg to areg.
// Also contains an independent retriggerable monostable driving q.
//
//   state | meaning
//   IDLE  | waiting for ev1; trig and abort ignored
//   ARMED | counting trig pulses toward TRIG_COUNT
//   DELAY | counting down delay_cyc before the transfer
module event_sequence_ctrl #(
  parameter int TRIG_COUNT  = 3,
  parameter int DELAY_W     = 8,
  parameter int DATA_W      = 8,
  parameter int MONO_CYCLES = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ev1,
  input  logic               trig,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delay_cyc,
  input  logic [DATA_W-1:0]  breg,
  input  logic               retrig,
  output logic [DATA_W-1:0]  areg,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2
  } state_t;

  localparam logic [7:0]  TRIG_LAST = 8'(TRIG_COUNT - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(MONO_CYCLES);

  state_t             state, state_nxt;
  logic [7:0]         trig_cnt, trig_cnt_nxt;
  logic [DELAY_W-1:0] dly_cnt, dly_cnt_nxt;
  logic [DATA_W-1:0]  areg_nxt;
  logic               done_nxt, aborted_nxt;
  logic [15:0]        hold_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      trig_cnt <= '0;
      dly_cnt  <= '0;
      areg     <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_nxt;
      trig_cnt <= trig_cnt_nxt;
      dly_cnt  <= dly_cnt_nxt;
      areg     <= areg_nxt;
      done     <= done_nxt;
      aborted  <= aborted_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    trig_cnt_nxt = trig_cnt;
    dly_cnt_nxt  = dly_cnt;
    areg_nxt     = areg;
    done_nxt     = 1'b0;
    aborted_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (ev1 && !abort) begin
          state_nxt    = ARMED;
          trig_cnt_nxt = '0;
        end
      end
      ARMED: begin
        // abort outranks a simultaneous trig, including the final one
        if (abort) begin
          state_nxt    = IDLE;
          trig_cnt_nxt = '0;
          dly_cnt_nxt  = '0;
          aborted_nxt  = 1'b1;
        end else if (trig) begin
          if (trig_cnt == TRIG_LAST) begin
            state_nxt    = DELAY;
            trig_cnt_nxt = '0;
            dly_cnt_nxt  = delay_cyc;
          end else if (trig_cnt != 8'hFF) begin
            trig_cnt_nxt = trig_cnt + 8'd1;
          end
        end
      end
      DELAY: begin
        if (abort) begin
          state_nxt    = IDLE;
          trig_cnt_nxt = '0;
          dly_cnt_nxt  = '0;
          aborted_nxt  = 1'b1;
        end else if (dly_cnt == '0) begin
          state_nxt = IDLE;
          areg_nxt  = breg;
          done_nxt  = 1'b1;
        end else begin
          dly_cnt_nxt = dly_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        trig_cnt_nxt = '0;
        dly_cnt_nxt  = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // q tracks a nonzero hold count, so it drops exactly MONO_CYCLES edges after the last retrig
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (retrig) begin
      hold_cnt <= HOLD_LOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 16'd1;
    end
  end

  assign q = (hold_cnt != '0);

endmodule

// File: tb/tb_event_sequence_ctrl.sv
// Bench for event_sequence_ctrl: directed table, hand-written corner sequences,
// and random stimulus checked against a timestamp-based reference model.
module tb_event_sequence_ctrl;

  logic       clk = 1'b0;
  logic       rst, ev1, trig, abort, retrig;
  logic [7:0] delay_cyc, breg;
  logic [7:0] areg, areg1;
  logic       busy, done, aborted, q;
  logic       busy1, done1, aborted1, q1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  event_sequence_ctrl u_dut (
    .clk(clk), .reset(rst), .ev1(ev1), .trig(trig), .abort(abort),
    .delay_cyc(delay_cyc), .breg(breg), .retrig(retrig),
    .areg(areg), .busy(busy), .done(done), .aborted(aborted), .q(q)
  );

  event_sequence_ctrl #(.TRIG_COUNT(1), .MONO_CYCLES(5)) u_dut1 (
    .clk(clk), .reset(rst), .ev1(ev1), .trig(trig), .abort(abort),
    .delay_cyc(delay_cyc), .breg(breg), .retrig(retrig),
    .areg(areg1), .busy(busy1), .done(done1), .aborted(aborted1), .q(q1)
  );

  typedef struct {
    logic       r, e, t, a;
    logic [7:0] d, b;
    logic       x_busy, x_done, x_ab;
    logic [7:0] x_areg;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic r, input logic e, input logic t, input logic a,
                              input logic [7:0] d, input logic [7:0] b,
                              input logic xb, input logic xd, input logic xa,
                              input logic [7:0] xr);
    vec_t v;
    v.r = r; v.e = e; v.t = t; v.a = a; v.d = d; v.b = b;
    v.x_busy = xb; v.x_done = xd; v.x_ab = xa; v.x_areg = xr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic t, input logic a,
                       input logic [7:0] d, input logic [7:0] b, input logic rt);
    rst = r; ev1 = e; trig = t; abort = a; delay_cyc = d; breg = b; retrig = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: transfer scheduled by absolute cycle number, monostable by time since last retrig.
  int         m_phase;   // 0 idle, 1 counting trigs, 2 waiting for transfer
  int         m_trigs, m_due, m_cyc, m_last_rt;
  logic [7:0] m_areg;
  logic       m_done, m_ab;

  task automatic model_edge();
    m_cyc++;
    m_done = 1'b0;
    m_ab   = 1'b0;
    if (rst) begin
      m_phase = 0; m_trigs = 0; m_areg = 8'h00; m_last_rt = -1000000;
    end else begin
      if (retrig) m_last_rt = m_cyc;
      if (m_phase == 0) begin
        if (ev1 && !abort) begin m_phase = 1; m_trigs = 0; end
      end else if (abort) begin
        m_phase = 0; m_ab = 1'b1;
      end else if (m_phase == 1) begin
        if (trig) begin
          m_trigs++;
          if (m_trigs == 3) begin m_phase = 2; m_due = m_cyc + 1 + int'(delay_cyc); end
        end
      end else if (m_cyc == m_due) begin
        m_areg = breg; m_done = 1'b1; m_phase = 0;
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h3C);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h3C);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h3C);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h3C);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h77, 1'b0, 1'b0, 1'b0, 8'h3C);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].b, 1'b0);
      tick();
      chk($sformatf("tbl%0d_busy", i), 16'(busy), 16'(tbl[i].x_busy));
      chk($sformatf("tbl%0d_done", i), 16'(done), 16'(tbl[i].x_done));
      chk($sformatf("tbl%0d_aborted", i), 16'(aborted), 16'(tbl[i].x_ab));
      chk($sformatf("tbl%0d_areg", i), 16'(areg), 16'(tbl[i].x_areg));
    end

    // Nominal latency: arm at edge 1, trigs at 3/5/9, delay 4 -> transfer at edge 14
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'hA5, 1'b0);
    tick();
    for (int c = 1; c <= 15; c++) begin
      drive(1'b0, 1'(c == 1), 1'(c == 3 || c == 5 || c == 9), 1'b0, 8'd4, 8'hA5, 1'b0);
      tick();
      if (c == 1)  chk("nom_busy_c2", 16'(busy), 16'd1);
      if (c == 13) begin
        chk("nom_areg_e13", 16'(areg), 16'h00);
        chk("nom_busy_e13", 16'(busy), 16'd1);
      end
      if (c == 14) begin
        chk("nom_areg_e14", 16'(areg), 16'hA5);
        chk("nom_done_c15", 16'(done), 16'd1);
        chk("nom_busy_c15", 16'(busy), 16'd0);
      end
      if (c == 15) chk("nom_done_width", 16'(done), 16'd0);
    end

    // Monostable: retrig at edges 10 and 100 -> q high from 10, low at 350
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0);
    tick();
    for (int c = 1; c <= 351; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'(c == 10 || c == 100));
      tick();
      if (c == 9)   chk("mono_q_e9", 16'(q), 16'd0);
      if (c == 10)  chk("mono_q_e10", 16'(q), 16'd1);
      if (c == 349) chk("mono_q_e349", 16'(q), 16'd1);
      if (c == 350) chk("mono_q_e350", 16'(q), 16'd0);
    end

    // Retrig held high keeps q up; release gives a full hold period
    for (int c = 0; c < 600; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
      tick();
    end
    chk("mono_held_q", 16'(q), 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0);
    for (int c = 0; c < 249; c++) tick();
    chk("mono_release_q_249", 16'(q), 16'd1);
    tick();
    chk("mono_release_q_250", 16'(q), 16'd0);

    // Reset mid-sequence with q high discards everything
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h5A, 1'b0); tick(); tick(); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0); tick();
    chk("rst_pre_areg", 16'(areg), 16'h5A);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h5A, 1'b0); tick(); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b1); tick();
    chk("rst_pre_q", 16'(q), 16'd1);
    chk("rst_pre_busy", 16'(busy), 16'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'h5A, 1'b1); tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_aborted", 16'(aborted), 16'd0);
    chk("rst_q", 16'(q), 16'd0);
    chk("rst_areg", 16'(areg), 16'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h5A, 1'b0); tick();
    chk("rst_needs_ev1", 16'(busy), 16'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h5A, 1'b0); tick(); tick();
    chk("rst_two_trigs_busy", 16'(busy), 16'd1);
    chk("rst_two_trigs_done", 16'(done), 16'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0); tick();
    chk("rst_third_trig_areg", 16'(areg), 16'h5A);
    chk("rst_third_trig_done", 16'(done), 16'd1);

    // Single-trig instance, zero delay: transfer on the edge after the trig
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'hC3, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'hC3, 1'b0); tick();
    chk("tc1_busy_k", 16'(busy1), 16'd1);
    chk("tc1_areg_k", 16'(areg1), 16'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hC3, 1'b0); tick();
    chk("tc1_areg_k1", 16'(areg1), 16'hC3);
    chk("tc1_done_k1", 16'(done1), 16'd1);
    chk("tc1_busy_k1", 16'(busy1), 16'd0);
    tick();
    chk("tc1_done_width", 16'(done1), 16'd0);

    // Random stimulus against the reference model
    m_cyc = 0; m_phase = 0; m_trigs = 0; m_due = 0; m_last_rt = -1000000;
    m_areg = 8'h00; m_done = 1'b0; m_ab = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      drive(1'(i < 2 || $urandom_range(0, 199) == 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0),
            8'($urandom_range(0, 5)),
            8'($urandom),
            1'($urandom_range(0, 39) == 0));
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_busy", 16'(busy), 16'(m_phase != 0));
      chk("rnd_done", 16'(done), 16'(m_done));
      chk("rnd_aborted", 16'(aborted), 16'(m_ab));
      chk("rnd_areg", 16'(areg), 16'(m_areg));
      chk("rnd_q", 16'(q), 16'((m_cyc - m_last_rt) < 250));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_sequence_ctrl.md
EVENT_SEQUENCE_CTRL -- requirements
Module: event_sequence_ctrl

Interface
REQ-001 SHALL have parameter TRIG_COUNT, default 3: trig pulses required after arming (range 1..255).
REQ-002 SHALL have parameter DELAY_W, default 8: width of delay_cyc and of the internal delay counter.
REQ-003 SHALL have parameter DATA_W, default 8: width of breg/areg.
REQ-004 SHALL have parameter MONO_CYCLES, default 250: monostable hold time in clk cycles (range 1..65535).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ev1  input  1  arm request, sampled each cycle.
REQ-008 SHALL have port trig  input  1  trigger, one count per cycle high.
REQ-009 SHALL have port abort  input  1  cancels an in-progress sequence.
REQ-010 SHALL have port delay_cyc  input  DELAY_W  delay before transfer, captured on entry to DELAY.
REQ-011 SHALL have port breg  input  DATA_W  source data, sampled in the transfer cycle.
REQ-012 SHALL have port retrig  input  1  monostable (re)trigger.
REQ-013 SHALL have port areg  output  DATA_W  registered destination of the transfer.
REQ-014 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse, registered, in the cycle after the transfer edge.
REQ-016 SHALL have port aborted  output  1  one-cycle pulse, registered, after an accepted abort.
REQ-017 SHALL have port q  output  1  monostable output.

Function
REQ-018 SHALL implement the sequencer FSM with states IDLE, ARMED and DELAY.
REQ-019 IDLE: on ev1=1 and abort=0 SHALL go to ARMED with the trig counter cleared; trig is ignored in IDLE.
REQ-020 ARMED: each cycle with trig=1 SHALL increment the trig counter; the trig seen at count TRIG_COUNT-1 SHALL move the FSM to DELAY and load the delay counter with delay_cyc.
REQ-021 DELAY: delay counter = 0 -> areg <= breg, done=1 next cycle, FSM to IDLE; otherwise SHALL decrement by 1.
REQ-022 Latency: final trig sampled at edge k -> areg SHALL update at edge k+1+delay_cyc; delay_cyc=0 -> transfer at edge k+1.
REQ-023 ev1 SHALL be ignored in ARMED and DELAY; re-arming only from IDLE.
REQ-024 abort=1 in ARMED or DELAY SHALL force IDLE on the same edge with aborted=1 next cycle, no areg update, counters cleared.
REQ-025 abort SHALL take priority over simultaneous trig, ev1, or a due transfer (delay counter = 0); areg is left unchanged.
REQ-026 abort in IDLE SHALL have no effect and SHALL NOT pulse aborted; ev1 with abort in IDLE SHALL keep the FSM in IDLE.
REQ-027 done and aborted SHALL never be high in the same cycle and SHALL be exactly one cycle wide.
REQ-028 Monostable, independent of the FSM: retrig=1 at edge k SHALL set q=1 and load the hold counter with MONO_CYCLES.
REQ-029 With no further retrig, q SHALL fall at edge k+MONO_CYCLES; each retrig while q=1 SHALL restart the full hold period.
REQ-030 retrig held high continuously SHALL keep q=1 indefinitely.
REQ-031 Trig and hold counters SHALL saturate/stop and never wrap.

Reset
REQ-032 reset=1 at an edge SHALL force FSM=IDLE, all counters=0, areg=0, busy=0, done=0, aborted=0, q=0, regardless of other inputs.
REQ-033 reset mid-sequence or mid-monostable SHALL discard all progress; the first arm after reset SHALL need a fresh ev1.

Verification
REQ-034 Defaults, breg=8'hA5, delay_cyc=4: ev1, then trig at cycles 3, 5 and 9 -> busy 1 from cycle 2, areg=8'hA5 at edge 14, done high in cycle 15, busy 0.
REQ-035 Abort while in DELAY with delay counter = 0 -> aborted pulse, areg unchanged, done never asserted.
REQ-036 trig before ev1, and ev1 during ARMED -> trig count unaffected; the transfer occurs only after 3 post-arm trigs.
REQ-037 retrig at cycle 10, again at cycle 100, MONO_CYCLES=250 -> q=1 from edge 10, q=0 at edge 350.
REQ-038 reset pulsed during ARMED (2 trigs counted) and q=1 -> all outputs 0; the next ev1 needs 3 new trigs.
REQ-039 delay_cyc=0, TRIG_COUNT=1: ev1 then trig at edge k -> areg updated at edge k+1, done high in the following cycle.
